// File: rtl/branch_predict_bht.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_bht
// Brief    : Direct-mapped BHT of 2-bit saturating counters with tag/target;
//            optional same-cycle update->lookup forwarding via BPRED_FORWARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predict_bht #(
  parameter int INDEX_W = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        f_valid,
  input  logic [31:0] f_pc,
  output logic        f_pred_hit,
  output logic        f_pred_taken,
  output logic [31:0] f_pred_target,
  input  logic        d_upd_valid,
  input  logic [31:0] d_upd_pc,
  input  logic        d_upd_taken,
  input  logic [31:0] d_upd_target,
  input  logic        d_upd_pred_taken,
  input  logic [31:0] d_upd_pred_target,
  output logic        d_mispredict,
  output logic [31:0] d_redirect_pc
);

  localparam int          C_ENTRIES  = 1 << INDEX_W;
  localparam int          C_TAG_W    = 30 - INDEX_W;
  localparam logic [1:0]  C_CTR_INIT = 2'b01;
  localparam logic [1:0]  C_CTR_ALLOC = 2'b10;

  logic               r_valid  [C_ENTRIES];
  logic [C_TAG_W-1:0] r_tag    [C_ENTRIES];
  logic [31:0]        r_target [C_ENTRIES];
  logic [1:0]         r_ctr    [C_ENTRIES];

  logic [INDEX_W-1:0] w_f_idx;
  logic [C_TAG_W-1:0] w_f_tag;
  logic [INDEX_W-1:0] w_u_idx;
  logic [C_TAG_W-1:0] w_u_tag;
  logic               w_u_hit;
  logic               w_u_we;
  logic               w_n_valid;
  logic [C_TAG_W-1:0] w_n_tag;
  logic [31:0]        w_n_target;
  logic [1:0]         w_n_ctr;
  logic               w_l_valid;
  logic [C_TAG_W-1:0] w_l_tag;
  logic [31:0]        w_l_target;
  logic [1:0]         w_l_ctr;
  logic               w_l_hit;
  logic               w_unused;

  assign w_f_idx  = f_pc[INDEX_W+1:2];
  assign w_f_tag  = f_pc[31:INDEX_W+2];
  assign w_u_idx  = d_upd_pc[INDEX_W+1:2];
  assign w_u_tag  = d_upd_pc[31:INDEX_W+2];
  assign w_u_hit  = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  assign w_unused = ^f_pc[1:0];

  // Post-update image of the entry addressed by the resolving branch.
  always_comb begin
    w_u_we     = 1'b0;
    w_n_valid  = r_valid[w_u_idx];
    w_n_tag    = r_tag[w_u_idx];
    w_n_target = r_target[w_u_idx];
    w_n_ctr    = r_ctr[w_u_idx];
    if (d_upd_valid) begin
      if (w_u_hit) begin
        w_u_we = 1'b1;
        if (d_upd_taken) begin
          w_n_target = d_upd_target;
          if (r_ctr[w_u_idx] != 2'b11) w_n_ctr = r_ctr[w_u_idx] + 2'd1;
        end else begin
          if (r_ctr[w_u_idx] != 2'b00) w_n_ctr = r_ctr[w_u_idx] - 2'd1;
        end
      end else if (d_upd_taken) begin
        w_u_we     = 1'b1;
        w_n_valid  = 1'b1;
        w_n_tag    = w_u_tag;
        w_n_target = d_upd_target;
        w_n_ctr    = C_CTR_ALLOC;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < C_ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= C_CTR_INIT;
      end
    end else if (w_u_we) begin
      r_valid[w_u_idx]  <= w_n_valid;
      r_tag[w_u_idx]    <= w_n_tag;
      r_target[w_u_idx] <= w_n_target;
      r_ctr[w_u_idx]    <= w_n_ctr;
    end
  end

  always_comb begin
    w_l_valid  = r_valid[w_f_idx];
    w_l_tag    = r_tag[w_f_idx];
    w_l_target = r_target[w_f_idx];
    w_l_ctr    = r_ctr[w_f_idx];
`ifdef BPRED_FORWARD_EN
    if (d_upd_valid && (w_u_idx == w_f_idx)) begin
      w_l_valid  = w_n_valid;
      w_l_tag    = w_n_tag;
      w_l_target = w_n_target;
      w_l_ctr    = w_n_ctr;
    end
`endif
  end

  assign w_l_hit       = f_valid && w_l_valid && (w_l_tag == w_f_tag);
  assign f_pred_hit    = w_l_hit;
  assign f_pred_taken  = w_l_hit && w_l_ctr[1];
  assign f_pred_target = (w_l_hit && w_l_ctr[1]) ? w_l_target : 32'd0;

  // Not-taken resumes after the delay slot.
  assign d_mispredict  = d_upd_valid &&
                         ((d_upd_taken != d_upd_pred_taken) ||
                          (d_upd_taken && (d_upd_pred_target != d_upd_target)));
  assign d_redirect_pc = !d_mispredict ? 32'd0 :
                         (d_upd_taken ? d_upd_target : d_upd_pc + 32'd8);

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_bht.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predict_bht
// Brief    : Self-checking bench: directed literal checks plus randomized
//            traffic compared every cycle against a behavioural table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predict_bht;

  localparam int IW = 6;
  localparam int NENT = 1 << IW;

  typedef struct {
    bit          valid;
    int unsigned tag;
    logic [31:0] target;
    int          ctr;
  } ent_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        f_valid = 1'b0;
  logic [31:0] f_pc = '0;
  logic        f_pred_hit;
  logic        f_pred_taken;
  logic [31:0] f_pred_target;
  logic        d_upd_valid = 1'b0;
  logic [31:0] d_upd_pc = '0;
  logic        d_upd_taken = 1'b0;
  logic [31:0] d_upd_target = '0;
  logic        d_upd_pred_taken = 1'b0;
  logic [31:0] d_upd_pred_target = '0;
  logic        d_mispredict;
  logic [31:0] d_redirect_pc;

  int n_checks = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  ent_t m [NENT];

  branch_predict_bht #(.INDEX_W(IW)) dut (
    .clk(clk), .resetn(resetn),
    .f_valid(f_valid), .f_pc(f_pc),
    .f_pred_hit(f_pred_hit), .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target),
    .d_upd_valid(d_upd_valid), .d_upd_pc(d_upd_pc), .d_upd_taken(d_upd_taken),
    .d_upd_target(d_upd_target), .d_upd_pred_taken(d_upd_pred_taken),
    .d_upd_pred_target(d_upd_pred_target),
    .d_mispredict(d_mispredict), .d_redirect_pc(d_redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % NENT);
  endfunction

  function automatic int unsigned tag_of(logic [31:0] pc);
    return int'(pc >> (IW + 2));
  endfunction

  // Entry contents after a resolved branch is applied to it.
  function automatic ent_t apply(ent_t e, logic [31:0] pc, logic tk, logic [31:0] tgt);
    ent_t r = e;
    if (e.valid && e.tag == tag_of(pc)) begin
      if (tk) begin
        r.ctr = (e.ctr + 1 > 3) ? 3 : e.ctr + 1;
        r.target = tgt;
      end else begin
        r.ctr = (e.ctr - 1 < 0) ? 0 : e.ctr - 1;
      end
    end else if (tk) begin
      r.valid = 1'b1;
      r.tag = tag_of(pc);
      r.target = tgt;
      r.ctr = 2;
    end
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NENT; i++) begin
        m[i].valid <= 1'b0;
        m[i].tag <= 0;
        m[i].target <= '0;
        m[i].ctr <= 1;
      end
    end else if (d_upd_valid) begin
      m[idx_of(d_upd_pc)] <= apply(m[idx_of(d_upd_pc)], d_upd_pc, d_upd_taken, d_upd_target);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      ent_t e;
      logic hit, tk, misp;
      logic [31:0] tgt, rpc;
      e = m[idx_of(f_pc)];
`ifdef BPRED_FORWARD_EN
      if (d_upd_valid && idx_of(d_upd_pc) == idx_of(f_pc))
        e = apply(e, d_upd_pc, d_upd_taken, d_upd_target);
`endif
      hit = f_valid && e.valid && (e.tag == tag_of(f_pc));
      tk  = hit && (e.ctr >= 2);
      tgt = tk ? e.target : 32'd0;
      misp = d_upd_valid && ((d_upd_taken != d_upd_pred_taken) ||
                             (d_upd_taken && d_upd_pred_target != d_upd_target));
      rpc = !misp ? 32'd0 : (d_upd_taken ? d_upd_target : d_upd_pc + 32'd8);
      check("model_hit", {31'd0, f_pred_hit}, {31'd0, hit});
      check("model_taken", {31'd0, f_pred_taken}, {31'd0, tk});
      check("model_target", f_pred_target, tgt);
      check("model_mispredict", {31'd0, d_mispredict}, {31'd0, misp});
      check("model_redirect", d_redirect_pc, rpc);
    end
  end

  task automatic step(input logic fv, input logic [31:0] fpc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt);
    f_valid = fv; f_pc = fpc;
    d_upd_valid = uv; d_upd_pc = upc; d_upd_taken = ut; d_upd_target = utgt;
    d_upd_pred_taken = upt; d_upd_pred_target = uptgt;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt);
    step(1'b0, 32'd0, 1'b1, pc, tk, tgt, ptk, ptgt);
  endtask

  localparam logic [31:0] PC_B = 32'hBFC00010;
  localparam logic [31:0] TG_B = 32'hBFC00100;

  initial begin
    #2 resetn = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    look(PC_B);
    check("reset_hit", {31'd0, f_pred_hit}, 32'd0);
    check("reset_taken", {31'd0, f_pred_taken}, 32'd0);
    check("reset_target", f_pred_target, 32'd0);
    adv();

    upd(PC_B, 1'b1, TG_B, 1'b0, 32'd0);
    check("alloc_mispredict", {31'd0, d_mispredict}, 32'd1);
    check("alloc_redirect", d_redirect_pc, TG_B);
    adv();
    look(PC_B);
    check("alloc_hit", {31'd0, f_pred_hit}, 32'd1);
    check("alloc_taken", {31'd0, f_pred_taken}, 32'd1);
    check("alloc_target", f_pred_target, TG_B);
    adv();

    for (int i = 0; i < 3; i++) begin
      upd(PC_B, 1'b1, TG_B, 1'b1, TG_B);
      check("taken_ok_mispredict", {31'd0, d_mispredict}, 32'd0);
      adv();
    end
    upd(PC_B, 1'b0, 32'd0, 1'b1, TG_B);
    check("nt_mispredict", {31'd0, d_mispredict}, 32'd1);
    check("nt_redirect", d_redirect_pc, 32'hBFC00018);
    adv();
    look(PC_B);
    check("sat3_still_taken", {31'd0, f_pred_taken}, 32'd1);
    adv();
    upd(PC_B, 1'b0, 32'd0, 1'b1, TG_B);
    adv();
    look(PC_B);
    check("flip_hit", {31'd0, f_pred_hit}, 32'd1);
    check("flip_not_taken", {31'd0, f_pred_taken}, 32'd0);
    check("flip_target_zero", f_pred_target, 32'd0);
    adv();
    upd(PC_B, 1'b0, 32'd0, 1'b0, 32'd0);
    check("nt_ok_redirect", d_redirect_pc, 32'd0);
    adv();
    upd(PC_B, 1'b0, 32'd0, 1'b0, 32'd0);
    adv();
    upd(PC_B, 1'b1, TG_B, 1'b0, 32'd0);
    adv();
    look(PC_B);
    check("sat0_then_taken", {31'd0, f_pred_taken}, 32'd0);
    adv();

    upd(32'h00400000, 1'b1, 32'h00400040, 1'b0, 32'd0);
    adv();
    upd(32'h00400100, 1'b1, 32'h00400200, 1'b0, 32'd0);
    adv();
    look(32'h00400000);
    check("alias_old_miss", {31'd0, f_pred_hit}, 32'd0);
    adv();
    look(32'h00400100);
    check("alias_new_hit", {31'd0, f_pred_hit}, 32'd1);
    check("alias_new_target", f_pred_target, 32'h00400200);
    adv();
    upd(32'h00400100, 1'b0, 32'd0, 1'b1, 32'h00400200);
    adv();
    look(32'h00400100);
    check("alias_ctr2_dec", {31'd0, f_pred_taken}, 32'd0);
    adv();

    step(1'b1, 32'h00000050, 1'b1, 32'h00000050, 1'b1, 32'h00001000, 1'b0, 32'd0);
`ifdef BPRED_FORWARD_EN
    check("fwd_hit", {31'd0, f_pred_hit}, 32'd1);
    check("fwd_target", f_pred_target, 32'h00001000);
`else
    check("nofwd_hit", {31'd0, f_pred_hit}, 32'd0);
    check("nofwd_target", f_pred_target, 32'd0);
`endif
    adv();

    for (int i = 0; i < 4; i++) begin
      upd(32'h00000100 + 32'(4 * i), 1'b1, 32'h00002000 + 32'(i), 1'b0, 32'd0);
      adv();
    end
    look(32'h00000104);
    check("pre_reset_hit", {31'd0, f_pred_hit}, 32'd1);
    @(posedge clk);
    #2 resetn = 1'b0;
    step(1'b1, 32'h00000104, 1'b1, 32'h00000110, 1'b1, 32'h00003000, 1'b0, 32'd0);
    check("in_reset_miss", {31'd0, f_pred_hit}, 32'd0);
    adv();
    resetn = 1'b1;
    look(32'h00000110);
    check("reset_upd_dropped", {31'd0, f_pred_hit}, 32'd0);
    adv();
    look(32'h0000010C);
    check("post_reset_miss", {31'd0, f_pred_hit}, 32'd0);
    adv();

    for (int n = 0; n < 2000; n++) begin
      logic [31:0] fpc, upc, tgt, ptgt;
      logic uv, tk, ptk;
      ent_t e;
      fpc = {24'h000040 + 24'($urandom_range(0, 3)), 6'($urandom_range(0, 5)), 2'b00};
      upc = $urandom_range(0, 1) ? fpc
                                 : {24'h000040 + 24'($urandom_range(0, 3)), 6'($urandom_range(0, 5)), 2'b00};
      uv = ($urandom_range(0, 3) != 0);
      tk = $urandom_range(0, 1);
      tgt = 32'h00008000 + 32'($urandom_range(0, 3) * 4);
      e = m[idx_of(upc)];
      if ($urandom_range(0, 3) != 0) begin
        ptk = e.valid && e.tag == tag_of(upc) && e.ctr >= 2;
        ptgt = ptk ? e.target : 32'd0;
      end else begin
        ptk = $urandom_range(0, 1);
        ptgt = 32'h00008000 + 32'($urandom_range(0, 3) * 4);
      end
      if ($urandom_range(0, 299) == 0) resetn = 1'b0;
      step($urandom_range(0, 3) != 0, fpc, uv, upc, tk, tgt, ptk, ptgt);
      adv();
      resetn = 1'b1;
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_predict_bht.md
# branch_predict_bht

Fetch-stage conditional-branch predictor for the MIPS pipeline: a direct-mapped branch history table of 2-bit saturating counters with per-entry tag and target. Fetch looks up the PC each cycle. Decode returns the resolved outcome of every conditional branch, taken from the branch comparator's `y`, together with the actual target. The block flags a mispredict and supplies the redirect PC.

## Interface
- `INDEX_W`, default 6: table index width; 2^INDEX_W entries; tag = `pc[31:INDEX_W+2]`.
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `f_valid`  in  1  fetch lookup valid.
- `f_pc`  in  32  fetch PC (word aligned).
- `f_pred_hit`  out  1  valid entry with matching tag.
- `f_pred_taken`  out  1  predicted taken: `f_valid & hit & ctr[1]`.
- `f_pred_target`  out  32  stored target; 0 when `f_pred_taken`=0.
- `d_upd_valid`  in  1  decode resolves one conditional branch (BEQ/BNE/BGTZ/BLEZ/BLTZ/BGEZ/BLTZAL/BGEZAL) this cycle.
- `d_upd_pc`  in  32  PC of the resolved branch.
- `d_upd_taken`  in  1  actual outcome (comparator `y`).
- `d_upd_target`  in  32  actual taken target.
- `d_upd_pred_taken`  in  1  prediction made in fetch for this branch, piped along.
- `d_upd_pred_target`  in  32  predicted target, piped along.
- `d_mispredict`  out  1  redirect required.
- `d_redirect_pc`  out  32  correct next-fetch PC.

## Operation
- Entry fields: `valid`, `tag`, `target[31:0]`, `ctr[1:0]`. Index = `pc[INDEX_W+1:2]`.
- Lookup is combinational from table registers.
- `d_mispredict = d_upd_valid & ((d_upd_taken != d_upd_pred_taken) | (d_upd_taken & d_upd_pred_target != d_upd_target))`.
- `d_redirect_pc` = `d_upd_taken ? d_upd_target : d_upd_pc + 8`, accounting for the delay slot. It is 0 when `d_mispredict`=0. Addition is 32-bit and wraps modulo 2^32.
- Update at the clock edge when `d_upd_valid`:
  - Hit, taken: `ctr` = min(ctr+1, 3); `target` ← `d_upd_target`.
  - Hit, not taken: `ctr` = max(ctr−1, 0); target unchanged.
  - Miss, taken: allocate, overwriting any aliased entry. Set `valid`=1, tag, target, `ctr`=2'b10.
  - Miss, not taken: no write.
- At most one update per cycle. Lookup and update are independent ports.

## Timing
- Reset (async assert, sync deassert by the top level): every entry gets `valid`=0 and `ctr`=2'b01. With no inputs active, all outputs are 0.
- Lookup latency: 0 cycles, combinational.
- `d_mispredict` and `d_redirect_pc`: 0 cycles, combinational from the `d_upd_*` inputs.
- Table write becomes visible to lookup on the cycle after the update edge, unless forwarding is enabled (see Configuration).
- Reset asserted mid-stream: the table clears immediately. Any update presented in the same cycle as reset release is ignored if `resetn` is still low at that edge.
- Saturation: a counter at 3 stays 3 on taken; a counter at 0 stays 0 on not-taken.
- Aliasing: a different tag at the same index is a miss. A taken update replaces the entry.

## Configuration
- `BPRED_FORWARD_EN` defined: when `d_upd_valid` and `f_valid` are both asserted in the same cycle with equal index, the lookup returns the post-update entry value. This covers hit, ctr, target, and allocation.
- Not defined: the lookup always returns the pre-update table contents.

## Test plan
- Reset, then lookup of `f_pc`=0xBFC00010 -> `f_pred_hit`=0, `f_pred_taken`=0, `f_pred_target`=0.
- Update pc=0xBFC00010, taken, target=0xBFC00100, pred_taken=0 -> `d_mispredict`=1, `d_redirect_pc`=0xBFC00100. Next-cycle lookup -> hit=1, taken=1, target=0xBFC00100.
- Same branch, 3× taken then 3× not-taken -> ctr 2→3→3→3→2→1→0. Prediction flips to not-taken after the 2nd not-taken. Not-taken with pred_taken=1 -> `d_mispredict`=1, `d_redirect_pc`=0xBFC00018.
- INDEX_W=6: taken update at 0x00400000, then taken update at 0x00400100 (same index, new tag) -> lookup 0x00400000 misses; lookup 0x00400100 hits with ctr=2.
- Same-cycle lookup and update of an unallocated index, taken, target=0x1000 -> forwarding on: hit=1, taken=1, target=0x1000. Forwarding off: hit=0.
- Allocate 4 entries, assert `resetn`=0 for one cycle mid-stream -> all lookups miss and no update is written during reset.
